sd_crc16: RTL and testbench
===========================

Name: sd_crc16

Overview:
- Bit-serial CRC16 generator/checker for one SD-bus data line (CRC-16/XMODEM: polynomial x^16+x^12+x^5+1, init 0, MSB-first).
- One instance per DAT line in the D-line driver. It accumulates data bits while receiving or sending a block.
- It then unloads the 16-bit remainder serially, MSB first. The driver transmits these bits or compares them against the received CRC.

Parameters:
- POLY, 16'h1021, generator polynomial with the implicit x^16 term omitted.
- INIT, 16'h0000, register value after reset.

Ports:
- iclk  input  1  SD clock; all state changes on the rising edge.
- irst_n  input  1  asynchronous active-low reset; forces the register to INIT.
- idata  input  1  serial data bit, consumed while iunload=0.
- iunload  input  1  1 = shift the CRC out; 0 = accumulate idata.
- ocrc  output  1  current CRC output bit (register bit 15).

Behaviour:
- Internal state is a 16-bit register crc[15:0]. No other state exists.
- Reset:
  - irst_n=0 sets crc=INIT immediately, with no clock needed, and holds it while low.
  - ocrc is therefore INIT[15] (0 by default) during reset.
  - Deassertion is not synchronised inside the block.
- Accumulate (iunload=0), each rising edge:
  - fb = idata XOR crc[15].
  - crc <= {crc[14:0],1'b0} XOR (fb ? POLY : 16'h0).
  - One bit per clock; no enable, so every clock with iunload=0 consumes idata.
- Unload (iunload=1), each rising edge:
  - crc <= {crc[14:0],1'b0}; zero fill.
  - idata is ignored.
- ocrc = crc[15], purely combinational from the register. It does not depend on iunload, so no output register is added.
  - The first CRC bit (MSB) is valid in the same cycle iunload first rises, before any unload edge.
  - Bit k (k=0..15, MSB first) is valid after k unload edges.
- After 16 unload edges crc = 0 and ocrc = 0. Further unload edges keep it 0.
- Switching iunload back to 0 mid-unload resumes accumulation on the partially shifted register. No automatic clear; the caller resets between blocks via irst_n.
- Latency:
  - The CRC of N bits is complete in the register after the N-th accumulate edge.
  - It appears on ocrc in the following cycle(s) during unload.
- An asynchronous reset mid-accumulate or mid-unload aborts the operation and restarts from INIT.
- No X propagation: the register is always defined after reset.

Test Plan:
- Reset then hold iunload=0, idata=0 for 100 clocks -> crc stays 16'h0000, ocrc=0 throughout.
- Single bit idata=1 after reset, then iunload=1 for 16 clocks -> ocrc sequence 0001 0000 0010 0001 (16'h1021, MSB first), then ocrc=0.
- ASCII "123456789" fed MSB-first per byte (72 bits), then unload -> serial output 16'h31C3.
- 4096 bits of 1 (512 bytes 0xFF), then unload -> serial output 16'h7FA1 (SD spec example).
- Assert irst_n=0 asynchronously, between clock edges, midway through the 0xFF stream -> ocrc=0 immediately without a clock edge; after release, "123456789" yields 16'h31C3 again.
- During unload toggle idata randomly -> output sequence unchanged from the idata=0 case (idata ignored).

Source files
------------

// File: rtl/sd_crc16_if.sv
// Serial CRC16 lane bundle: data/unload in, CRC bit out.
interface sd_crc16_if;
  logic idata;
  logic iunload;
  logic ocrc;

  modport master (
    output idata,
    output iunload,
    input  ocrc
  );

  modport slave (
    input  idata,
    input  iunload,
    output ocrc
  );
endinterface

// File: rtl/sd_crc16.sv
// Bit-serial CRC-16/XMODEM generator/checker for one SD DAT line.
module sd_crc16 #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  // Unload is a plain zero-filled shift; idata only matters when accumulating.
  always_comb begin
    fb    = idata ^ crc_q[15];
    crc_d = {crc_q[14:0], 1'b0};
    if (!iunload && fb) begin
      crc_d = crc_d ^ POLY;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign ocrc = crc_q[15];

endmodule

// File: tb/tb_sd_crc16.sv
// Directed scoreboard bench for sd_crc16.
module tb_sd_crc16;

  logic iclk;
  logic irst_n;
  int   checks;
  int   errors;
  logic exp_q[$];
  logic [7:0] msg [9];

  sd_crc16_if bus ();

  sd_crc16 dut (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .idata   (bus.idata),
    .iunload (bus.iunload),
    .ocrc    (bus.ocrc)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic chk(input string tag, input logic exp);
    checks++;
    assert (bus.ocrc === exp) else begin
      errors++;
      $error("FAIL %s: ocrc=%b expected=%b", tag, bus.ocrc, exp);
    end
  endtask

  task automatic feed(input logic b);
    bus.iunload = 1'b0;
    bus.idata   = b;
    @(posedge iclk);
    #1;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) feed(b[i]);
  endtask

  task automatic feed_msg();
    for (int i = 0; i < 9; i++) feed_byte(msg[i]);
  endtask

  // Push the expected remainder MSB first plus two trailing zeros, then
  // pop one expected bit per unload cycle.
  task automatic unload(input string tag, input logic [15:0] exp,
                        input bit rnd);
    for (int k = 15; k >= 0; k--) exp_q.push_back(exp[k]);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    bus.iunload = 1'b1;
    while (exp_q.size() > 0) begin
      bus.idata = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge iclk);
      chk(tag, exp_q.pop_front());
      @(posedge iclk);
      #1;
    end
    bus.iunload = 1'b0;
    bus.idata   = 1'b0;
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    #3;
    chk("reset_hold", 1'b0);
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    msg         = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                    8'h36, 8'h37, 8'h38, 8'h39};
    irst_n      = 1'b1;
    bus.idata   = 1'b0;
    bus.iunload = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 100; i++) begin
      feed(1'b0);
      chk("zeros", 1'b0);
    end

    do_reset();
    feed(1'b1);
    unload("single_one", 16'h1021, 1'b0);

    do_reset();
    feed_msg();
    unload("ascii_9", 16'h31C3, 1'b0);

    do_reset();
    for (int i = 0; i < 512; i++) feed_byte(8'hFF);
    unload("ff_block", 16'h7FA1, 1'b0);

    // Async reset between edges mid-stream must clear without a clock.
    irst_n = 1'b1;
    for (int i = 0; i < 2047; i++) feed(1'b1);
    #2;
    irst_n = 1'b0;
    #1;
    chk("async_rst", 1'b0);
    @(posedge iclk);
    #1;
    chk("async_rst_held", 1'b0);
    irst_n = 1'b1;
    unload("after_rst_zero", 16'h0000, 1'b0);
    feed_msg();
    unload("ascii_after_rst", 16'h31C3, 1'b0);

    do_reset();
    feed_msg();
    unload("ascii_rand_idata", 16'h31C3, 1'b1);

    do_reset();
    feed(1'b1);
    unload("one_rand_idata", 16'h1021, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
